mux_scan_ctrl: RTL and testbench

Sequential select generator and result collector that sits directly upstream of the 4:1 behavioural multiplexer. On a start request it sweeps the mux select through channels 0..3, dwelling a programmable number of cycles on each channel. It samples the mux output at the end of each dwell window and presents the four sampled bits as one word with a single-cycle done pulse. Optional continuous mode re-arms the sweep back-to-back without a new start.

---
 rtl/mux_scan_ctrl_if.sv | 20 ++
 rtl/mux_scan_ctrl.sv | 101 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
// Handshake bundle between the scan controller and its surroundings.
//   start  : sweep request (environment -> ctrl)
//   cont   : continuous-mode enable (environment -> ctrl)
//   mux_y  : output of the downstream 4:1 mux (mux -> ctrl)
//   sel    : mux select (ctrl -> mux)
//   busy   : sweep in progress (ctrl -> environment)
//   done   : one-cycle pulse, word just updated (ctrl -> environment)
//   word   : captured result, word[k] = mux_y while sel == k
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       mux_y;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] word;

  modport master (output start, cont, mux_y, input sel, busy, done, word);
  modport slave  (input start, cont, mux_y, output sel, busy, done, word);
endinterface

// File: rtl/mux_scan_ctrl.sv
// Sweeps a 4:1 mux select through channels 0..3, dwelling DWELL cycles on
// each, sampling mux_y at the end of each dwell window. The four samples are
// published on word together with a one-cycle done pulse. With cont held
// high the sweep restarts immediately after DONE.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of mux_scan_ctrl_if (start/cont/mux_y in,
//            sel/busy/done/word out)
module mux_scan_ctrl #(
  parameter int DWELL = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_ctrl_if.slave bus
);

  generate
    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
      $error("mux_scan_ctrl: DWELL must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] sh_q, sh_d;
  logic [3:0] word_q, word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= 8'd0;
      sh_q    <= 4'd0;
      word_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          sel_d   = 2'd0;
          cnt_d   = 8'd0;
          sh_d    = 4'd0;
        end
      end
      SCAN: begin
        if (cnt_q == LAST) begin
          cnt_d        = 8'd0;
          sh_d[sel_q]  = bus.mux_y;
          if (sel_q == 2'd3) begin
            // word takes the shadow including the bit captured on this edge
            state_d = DONE;
            sel_d   = 2'd0;
            word_d  = sh_d;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // cont alone decides; a start arriving here is dropped
        if (bus.cont) begin
          state_d = SCAN;
          sel_d   = 2'd0;
          cnt_d   = 8'd0;
          sh_d    = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sel  = sel_q;
  assign bus.busy = (state_q == SCAN);
  assign bus.done = (state_q == DONE);
  assign bus.word = word_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_scan_ctrl_if b1 ();
  mux_scan_ctrl_if b2 ();
  mux_scan_ctrl_if b3 ();

  logic [3:0] d1, d2, d3;

  // behavioural 4:1 muxes downstream of each controller
  assign b1.mux_y = d1[b1.sel];
  assign b2.mux_y = d2[b2.sel];
  assign b3.mux_y = d3[b3.sel];

  mux_scan_ctrl #(.DWELL(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mux_scan_ctrl #(.DWELL(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  mux_scan_ctrl #(.DWELL(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  int checks = 0;
  int failures = 0;

  // outputs packed as {sel, busy, done, word}
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got sel=%0d busy=%0b done=%0b word=%b, want sel=%0d busy=%0b done=%0b word=%b",
               nm, act[7:6], act[5], act[4], act[3:0], exp[7:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  function automatic logic [7:0] pk(input logic [1:0] s, input logic b, input logic d,
                                    input logic [3:0] w);
    return {s, b, d, w};
  endfunction

  typedef struct {
    logic       start;
    logic       cont;
    logic [3:0] data;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic [3:0] word;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic ct, input logic [3:0] dt,
                              input logic [1:0] s, input logic b, input logic dn,
                              input logic [3:0] w);
    vec_t v;
    v.start = st; v.cont = ct; v.data = dt;
    v.sel = s; v.busy = b; v.done = dn; v.word = w;
    return v;
  endfunction

  // reference model state for the randomized run on the DWELL=2 instance
  int         mt;      // cycles since sweep start, -1 when idle
  logic [3:0] m_sh, m_word;
  localparam int MD = 2;

  initial begin
    b1.start = 0; b1.cont = 0;
    b2.start = 0; b2.cont = 0;
    b3.start = 0; b3.cont = 0;
    d1 = 0; d2 = 0; d3 = 0;

    // DWELL=1 sweep (channels 1,0,1,1)
    tbl.push_back(mk(1,0,4'b1101, 0,1,0,4'b0000));
    tbl.push_back(mk(0,0,4'b1101, 1,1,0,4'b0000));
    tbl.push_back(mk(0,0,4'b1101, 2,1,0,4'b0000));
    tbl.push_back(mk(0,0,4'b1101, 3,1,0,4'b0000));
    tbl.push_back(mk(0,0,4'b1101, 0,0,1,4'b1101));
    tbl.push_back(mk(0,0,4'b1101, 0,0,0,4'b1101));
    // start again while busy is ignored
    tbl.push_back(mk(1,0,4'b1010, 0,1,0,4'b1101));
    tbl.push_back(mk(0,0,4'b1010, 1,1,0,4'b1101));
    tbl.push_back(mk(1,0,4'b1010, 2,1,0,4'b1101));
    tbl.push_back(mk(0,0,4'b1010, 3,1,0,4'b1101));
    tbl.push_back(mk(0,0,4'b1010, 0,0,1,4'b1010));
    tbl.push_back(mk(0,0,4'b1010, 0,0,0,4'b1010));
    tbl.push_back(mk(0,0,4'b1010, 0,0,0,4'b1010));
    // continuous mode, data 1111 then 0000
    tbl.push_back(mk(1,1,4'b1111, 0,1,0,4'b1010));
    tbl.push_back(mk(0,1,4'b1111, 1,1,0,4'b1010));
    tbl.push_back(mk(0,1,4'b1111, 2,1,0,4'b1010));
    tbl.push_back(mk(0,1,4'b1111, 3,1,0,4'b1010));
    tbl.push_back(mk(0,1,4'b1111, 0,0,1,4'b1111));
    tbl.push_back(mk(0,1,4'b0000, 0,1,0,4'b1111));
    tbl.push_back(mk(0,1,4'b0000, 1,1,0,4'b1111));
    tbl.push_back(mk(0,1,4'b0000, 2,1,0,4'b1111));
    tbl.push_back(mk(0,1,4'b0000, 3,1,0,4'b1111));
    tbl.push_back(mk(0,0,4'b0000, 0,0,1,4'b0000));
    tbl.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000));

    // reset held 3 cycles, then idle 10 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_u1", pk(b1.sel, b1.busy, b1.done, b1.word), 8'h00);
      chk("reset_u3", pk(b3.sel, b3.busy, b3.done, b3.word), 8'h00);
    end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_u1", pk(b1.sel, b1.busy, b1.done, b1.word), 8'h00);
      chk("idle_u2", pk(b2.sel, b2.busy, b2.done, b2.word), 8'h00);
    end

    // table-driven DWELL=1 vectors
    foreach (tbl[i]) begin
      b1.start = tbl[i].start; b1.cont = tbl[i].cont; d1 = tbl[i].data;
      @(posedge clk); #1;
      chk($sformatf("tbl_%0d", i), pk(b1.sel, b1.busy, b1.done, b1.word),
          pk(tbl[i].sel, tbl[i].busy, tbl[i].done, tbl[i].word));
    end
    b1.start = 0; b1.cont = 0;

    // DWELL=3 sweep (channels 0,1,1,0)
    d3 = 4'b0110; b3.start = 1;
    @(posedge clk); #1; b3.start = 0;
    for (int t = 0; t < 12; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      chk($sformatf("d3_t%0d", t), pk(b3.sel, b3.busy, b3.done, b3.word),
          pk(2'(t / 3), 1'b1, 1'b0, 4'b0000));
    end
    @(posedge clk); #1;
    chk("d3_done", pk(b3.sel, b3.busy, b3.done, b3.word), pk(0, 0, 1, 4'b0110));
    @(posedge clk); #1;
    chk("d3_idle", pk(b3.sel, b3.busy, b3.done, b3.word), pk(0, 0, 0, 4'b0110));

    // DWELL=2, reset during channel 2
    d2 = 4'b1001; b2.start = 1;
    @(posedge clk); #1; b2.start = 0;
    for (int t = 1; t <= 4; t++) begin @(posedge clk); #1; end
    chk("d2_mid", pk(b2.sel, b2.busy, b2.done, b2.word), pk(2, 1, 0, 4'b0000));
    @(negedge clk); rst_n = 0; #1;
    chk("d2_rst_now", pk(b2.sel, b2.busy, b2.done, b2.word), 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("d2_rst_hold", pk(b2.sel, b2.busy, b2.done, b2.word), 8'h00);
    end
    @(negedge clk); rst_n = 1;
    b2.start = 1;
    @(posedge clk); #1; b2.start = 0;
    for (int t = 1; t < 8; t++) begin
      @(posedge clk); #1;
      chk("d2_again_nodone", {7'd0, b2.done}, 8'd0);
    end
    @(posedge clk); #1;
    chk("d2_again_done", pk(b2.sel, b2.busy, b2.done, b2.word), pk(0, 0, 1, 4'b1001));
    @(posedge clk); #1;
    chk("d2_again_idle", pk(b2.sel, b2.busy, b2.done, b2.word), pk(0, 0, 0, 4'b1001));

    // randomized run on DWELL=2 against a timeline model
    mt = -1; m_sh = 0; m_word = 4'b1001;
    for (int n = 0; n < 600; n++) begin
      logic [1:0] es;
      logic eb, ed;
      b2.start = ($urandom_range(0, 3) == 0);
      b2.cont  = ($urandom_range(0, 2) == 0);
      d2       = 4'($urandom);
      // model step for this edge
      if (mt < 0) begin
        if (b2.start) mt = 0;
      end else if (mt == 4 * MD) begin
        mt = b2.cont ? 0 : -1;
      end else begin
        if ((mt + 1) % MD == 0) m_sh[(mt + 1) / MD - 1] = d2[(mt + 1) / MD - 1];
        mt++;
        if (mt == 4 * MD) m_word = m_sh;
      end
      @(posedge clk); #1;
      eb = (mt >= 0 && mt < 4 * MD);
      ed = (mt == 4 * MD);
      es = eb ? 2'(mt / MD) : 2'd0;
      chk($sformatf("rand_%0d", n), pk(b2.sel, b2.busy, b2.done, b2.word),
          pk(es, eb, ed, m_word));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
